req_encoder_8to3: RTL and testbench



---
 rtl/req_encoder_8to3_pkg.sv | 14 +
 rtl/req_encoder_8to3_if.sv | 14 +
 rtl/req_encoder_8to3_pri_enc8.sv | 16 +
 rtl/req_encoder_8to3.sv | 62 ++++++
 tb/tb_req_encoder_8to3.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/req_encoder_8to3_pkg.sv
// Shared types and helpers for the 8-to-3 request encoder and its priority encoder.
package req_enc_pkg;
   localparam int N      = 8;
   localparam int CODE_W = 3;

   typedef enum logic {IDLE, OFFER} state_t;

   function automatic logic [N-1:0] code_mask(input logic [CODE_W-1:0] code);
      logic [N-1:0] m;
      m       = '0;
      m[code] = 1'b1;
      return m;
   endfunction
endpackage

// File: rtl/req_encoder_8to3_if.sv
// Request/offer bundle between request sources, the encoder and its consumer.
interface req_encoder_8to3_if #(parameter int CNT_W = 8);
   import req_enc_pkg::*;
   logic [N-1:0]      req;
   logic              En;
   logic              ready;
   logic [CODE_W-1:0] Y;
   logic              valid;
   logic [N-1:0]      pend;
   logic [CNT_W-1:0]  count;

   modport master (output req, En, ready, input Y, valid, pend, count);
   modport slave  (input req, En, ready, output Y, valid, pend, count);
endinterface

// File: rtl/req_encoder_8to3_pri_enc8.sv
// Combinational highest-index priority encoder; code is 0 when no bit is set.
module pri_enc8
   import req_enc_pkg::*;
(
   input  logic [N-1:0]      v,
   output logic [CODE_W-1:0] code,
   output logic              any
);
   always_comb begin
      code = '0;
      // Ascending scan: the last hit is the highest index.
      for (int i = 0; i < N; i++)
         if (v[i]) code = CODE_W'(i);
      any = |v;
   end
endmodule

// File: rtl/req_encoder_8to3.sv
// Latches request pulses and offers the highest pending index under valid/ready.
module req_encoder_8to3
   import req_enc_pkg::*;
#(
   parameter int CNT_W = 8
)(
   input  logic               clk,
   input  logic               rst,
   req_encoder_8to3_if.slave  bus
);
   state_t            state;
   logic [N-1:0]      pend_q, pend_next, clr;
   logic [CODE_W-1:0] y_q, code;
   logic              valid_q, any, hs, load;
   logic [CNT_W-1:0]  cnt_q;

   always_comb begin
      hs        = valid_q & bus.ready;
      clr       = hs ? code_mask(y_q) : '0;
      // Set wins: a new pulse on the served line keeps it pending.
      pend_next = (pend_q & ~clr) | bus.req;
      load      = bus.En & ((state == IDLE) | hs);
   end

   pri_enc8 u_pri (
      .v    (pend_next),
      .code (code),
      .any  (any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pend_q  <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pend_q <= pend_next;
         if (hs) cnt_q <= cnt_q + 1'b1;
         // An open offer is never changed until it is accepted.
         if (load) begin
            if (any) begin
               y_q     <= code;
               valid_q <= 1'b1;
               state   <= OFFER;
            end else begin
               valid_q <= 1'b0;
               state   <= IDLE;
            end
         end else if (hs) begin
            valid_q <= 1'b0;
            state   <= IDLE;
         end
      end
   end

   assign bus.Y     = y_q;
   assign bus.valid = valid_q;
   assign bus.pend  = pend_q;
   assign bus.count = cnt_q;
endmodule

// File: tb/tb_req_encoder_8to3.sv
// Directed plus randomized checks of req_encoder_8to3 against a behavioural model.
module tb_req_encoder_8to3;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   req_encoder_8to3_if #(.CNT_W(8)) bus ();

   req_encoder_8to3 #(.CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model: pending set, current offer and served count.
   logic [7:0] m_pend;
   logic       m_valid;
   int         m_y;
   int         m_cnt;

   function automatic int highest(input logic [7:0] v);
      for (int k = 7; k >= 0; k--)
         if (v[k]) return k;
      return -1;
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic [7:0] r, input logic en,
                       input logic rdy, input logic rs);
      logic       served;
      logic [7:0] np;
      int         h;
      @(negedge clk);
      bus.req = r; bus.En = en; bus.ready = rdy; rst = rs;
      @(posedge clk);
      if (rs) begin
         m_pend = '0; m_valid = 1'b0; m_y = 0; m_cnt = 0;
      end else begin
         served = m_valid && rdy;
         np     = m_pend;
         if (served) begin
            np[m_y] = 1'b0;
            m_cnt   = (m_cnt + 1) % 256;
         end
         np = np | r;
         if (en && (!m_valid || served)) begin
            h = highest(np);
            if (h >= 0) begin m_y = h; m_valid = 1'b1; end
            else m_valid = 1'b0;
         end else if (served) begin
            m_valid = 1'b0;
         end
         m_pend = np;
      end
      #1;
      chk({tag, ".valid"}, int'(bus.valid), int'(m_valid));
      chk({tag, ".pend"},  int'(bus.pend),  int'(m_pend));
      chk({tag, ".count"}, int'(bus.count), m_cnt);
      if (m_valid) chk({tag, ".Y"}, int'(bus.Y), m_y);
   endtask

   initial begin
      bus.req = '0; bus.En = 1'b0; bus.ready = 1'b0; rst = 1'b1;
      m_pend = '0; m_valid = 1'b0; m_y = 0; m_cnt = 0;

      // Reset
      step("rst0", 8'h00, 1'b0, 1'b0, 1'b1);
      step("rst1", 8'h00, 1'b0, 1'b0, 1'b1);
      chk("rst_Y", int'(bus.Y), 0);
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_count", int'(bus.count), 0);

      // Single request
      step("single", 8'h20, 1'b1, 1'b0, 1'b0);
      chk("single_Y", int'(bus.Y), 5);
      chk("single_pend", int'(bus.pend), 8'h20);
      step("hold", 8'h00, 1'b1, 1'b0, 1'b0);
      chk("hold_Y", int'(bus.Y), 5);
      step("accept", 8'h00, 1'b1, 1'b1, 1'b0);
      chk("accept_valid", int'(bus.valid), 0);
      chk("accept_count", int'(bus.count), 1);

      // Priority drain
      step("drain0", 8'h85, 1'b1, 1'b1, 1'b0);
      chk("drain_Y7", int'(bus.Y), 7);
      step("drain1", 8'h00, 1'b1, 1'b1, 1'b0);
      chk("drain_Y2", int'(bus.Y), 2);
      step("drain2", 8'h00, 1'b1, 1'b1, 1'b0);
      chk("drain_Y0", int'(bus.Y), 0);
      step("drain3", 8'h00, 1'b1, 1'b1, 1'b0);
      chk("drain_valid", int'(bus.valid), 0);
      chk("drain_count", int'(bus.count), 4);

      // Offer stability
      step("stab0", 8'h02, 1'b1, 1'b0, 1'b0);
      step("stab1", 8'h40, 1'b1, 1'b0, 1'b0);
      chk("stab_Y", int'(bus.Y), 1);
      chk("stab_pend", int'(bus.pend), 8'h42);
      step("stab2", 8'h00, 1'b1, 1'b1, 1'b0);
      chk("stab_Y6", int'(bus.Y), 6);
      step("stab3", 8'h00, 1'b1, 1'b1, 1'b0);

      // Set-wins collision
      step("sw0", 8'h08, 1'b1, 1'b0, 1'b0);
      step("sw1", 8'h08, 1'b1, 1'b1, 1'b0);
      chk("sw_Y", int'(bus.Y), 3);
      chk("sw_valid", int'(bus.valid), 1);
      chk("sw_pend", int'(bus.pend), 8'h08);
      chk("sw_count", int'(bus.count), 7);
      step("sw2", 8'h00, 1'b1, 1'b1, 1'b0);

      // En gating
      step("en0", 8'h10, 1'b0, 1'b0, 1'b0);
      chk("en_blocked", int'(bus.valid), 0);
      chk("en_pend", int'(bus.pend), 8'h10);
      step("en1", 8'h00, 1'b1, 1'b0, 1'b0);
      chk("en_rise_Y", int'(bus.Y), 4);
      step("en2", 8'h01, 1'b0, 1'b0, 1'b0);
      chk("en_drop_hold", int'(bus.valid), 1);
      step("en3", 8'h00, 1'b0, 1'b1, 1'b0);
      chk("en_noreload", int'(bus.valid), 0);
      chk("en_left", int'(bus.pend), 8'h01);
      step("en4", 8'h00, 1'b0, 1'b0, 1'b0);

      // Reset mid-offer
      step("mr0", 8'hFF, 1'b1, 1'b0, 1'b0);
      chk("mr_pend", int'(bus.pend), 8'hFF);
      step("mr1", 8'hFF, 1'b1, 1'b1, 1'b1);
      chk("mr_valid", int'(bus.valid), 0);
      chk("mr_pend0", int'(bus.pend), 0);
      chk("mr_Y", int'(bus.Y), 0);
      step("mr2", 8'h00, 1'b1, 1'b0, 1'b0);

      // Counter wrap: 256 back-to-back handshakes on line 0
      step("wrap0", 8'h01, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) step("wrap", 8'h01, 1'b1, 1'b1, 1'b0);
      chk("wrap_count", int'(bus.count), 0);
      chk("wrap_valid", int'(bus.valid), 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [7:0] r;
         r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         step("rand", r, ($urandom_range(0, 4) != 0), 1'($urandom),
              ($urandom_range(0, 60) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
